hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline control block that produces the write-enable seen by the PC register and the IF/ID and ID/EX control for the 5-stage MIPS core.
- Detects load-use hazards, holds the front end while the multi-cycle multiplier is busy, flushes on taken branches, and sequences the two-cycle exception entry (EPC capture, then vector redirect).
- Sits in ID, between the hazard inputs from ID/EX/MEM and the PC/IFID write enables.

Parameters:
- PC_WIDTH, 6, width of PC values, matching the PC register.
- MULT_CYCLES, 4, total stall cycles per multiply; legal range 2..15.
- CNT_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination register of that load.
- IFID_Rs  in  5  Rs source of the instruction in ID.
- IFID_Rt  in  5  Rt source of the instruction in ID.
- IFID_UsesRt  in  1  instruction in ID reads Rt.
- BranchTaken  in  1  branch or jump resolved taken in EX.
- MultStart  in  1  multiply issuing from ID this cycle.
- Exception  in  1  exception raised (overflow or illegal opcode).
- ExcCause  in  2  cause code sampled with Exception.
- PCWrite  out  1  PC register write enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEX_Bubble  out  1  zero the control fields entering ID/EX.
- IFID_Flush  out  1  clear IF/ID to a NOP.
- IDEX_Flush  out  1  clear ID/EX to a NOP.
- EPCWrite  out  1  capture the current PC into EPC.
- PCSrcExc  out  1  PC mux selects the exception vector.
- CauseOut  out  2  registered cause of the last exception.
- StallCycles  out  CNT_WIDTH  count of cycles with PCWrite=0 outside reset.

Behaviour:
- Reset (rst=0, async):
  - State goes to RUN; mult counter=0, CauseOut=0, StallCycles=0.
  - While rst=0, PCWrite=0 and IFIDWrite=0; all other outputs 0.
- Output decode: Moore on state plus Mealy on hazard inputs in RUN only. Zero latency, so a hazard seen in cycle N gates the PC edge at the end of cycle N.
- load_use = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
- Priority in RUN: Exception > BranchTaken > MultStart > load_use > none.
- RUN:
  - Exception: EPCWrite=1, PCWrite=0, IFID_Flush=1, IDEX_Flush=1. Latch ExcCause into CauseOut; next state EXC_VEC.
  - BranchTaken: PCWrite=1, IFIDWrite=1, IFID_Flush=1, IDEX_Flush=1; stay in RUN. A simultaneous load_use or MultStart is discarded, because that instruction is flushed.
  - MultStart: PCWrite=0, IFIDWrite=0, IDEX_Bubble=0 (the multiply itself advances). Load counter with MULT_CYCLES-1; next state MULT_BUSY.
  - load_use: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; stay in RUN. This gives exactly one stall cycle, since the next cycle sees no hazard.
  - none: PCWrite=1, IFIDWrite=1, all others 0.
- MULT_BUSY:
  - PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; counter decrements each cycle.
  - Moves to RUN in the cycle the counter reads 1, so total stall = MULT_CYCLES.
  - Exception aborts: same actions as the RUN exception case, counter cleared, next state EXC_VEC.
  - BranchTaken and MultStart are ignored.
- EXC_VEC: PCWrite=1, PCSrcExc=1, IFID_Flush=1; next state RUN unconditionally. Exception and all other inputs are masked for this one cycle.
- StallCycles:
  - Increments on every clocked cycle with PCWrite=0 while rst=1; saturates at all-ones and never wraps.
  - Counts load_use, MULT_BUSY, MultStart and exception-capture cycles.
- No output is X for any input combination. Unused state encodings return to RUN on the next edge with RUN outputs.

Test Plan:
- Free run, no hazards, 10 cycles -> PCWrite=1 and IFIDWrite=1 every cycle; StallCycles=0.
- Load to $5 with ID reading Rs=$5 -> PCWrite=0, IFIDWrite=0, IDEX_Bubble=1 for exactly 1 cycle, then PCWrite=1; StallCycles=1. Repeat with IDEX_Rt=0 -> no stall.
- MultStart with MULT_CYCLES=4 -> PCWrite=0 for 4 consecutive cycles, then 1; IDEX_Bubble=1 on cycles 2-4 only; StallCycles=4.
- BranchTaken together with load_use and MultStart -> IFID_Flush=IDEX_Flush=1, PCWrite=1, no stall, state stays RUN.
- Exception with ExcCause=2 in the 2nd MULT_BUSY cycle:
  - Next cycle: EPCWrite=1, PCWrite=0, both flushes set.
  - Cycle after: PCSrcExc=1, PCWrite=1.
  - CauseOut=2; a second Exception during EXC_VEC is ignored.
- Drive rst=0 asynchronously mid-MULT_BUSY -> PCWrite and IFIDWrite drop immediately, state returns to RUN, StallCycles=0. Normal fetch resumes on the first edge after release.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall control for the 5-stage MIPS pipeline: load-use stalls,
// multiplier hold, taken-branch flush and the two-cycle exception entry.
module hazard_stall_ctrl #(
    parameter int PC_WIDTH    = 6,
    parameter int MULT_CYCLES = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IDEX_MemRead,
    input  logic [4:0]           IDEX_Rt,
    input  logic [4:0]           IFID_Rs,
    input  logic [4:0]           IFID_Rt,
    input  logic                 IFID_UsesRt,
    input  logic                 BranchTaken,
    input  logic                 MultStart,
    input  logic                 Exception,
    input  logic [1:0]           ExcCause,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 IDEX_Bubble,
    output logic                 IFID_Flush,
    output logic                 IDEX_Flush,
    output logic                 EPCWrite,
    output logic                 PCSrcExc,
    output logic [1:0]           CauseOut,
    output logic [CNT_WIDTH-1:0] StallCycles
);

    if (MULT_CYCLES < 2 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
        $error("MULT_CYCLES must lie in 2..15");
    end
    if (PC_WIDTH < 1) begin : g_bad_pc_width
        $error("PC_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        MULT_BUSY = 2'b01,
        EXC_VEC   = 2'b10
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] mult_cnt, mult_cnt_nxt;
    logic [1:0] cause_nxt;
    logic       load_use;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            mult_cnt    <= 4'd0;
            CauseOut    <= 2'd0;
            StallCycles <= '0;
        end else begin
            state    <= state_nxt;
            mult_cnt <= mult_cnt_nxt;
            CauseOut <= cause_nxt;
            if (!PCWrite) begin
                StallCycles <= sat_inc(StallCycles);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        mult_cnt_nxt = mult_cnt;
        cause_nxt    = CauseOut;
        case (state)
            RUN: begin
                if (Exception) begin
                    state_nxt = EXC_VEC;
                    cause_nxt = ExcCause;
                end else if (BranchTaken) begin
                    state_nxt = RUN;
                end else if (MultStart) begin
                    state_nxt    = MULT_BUSY;
                    mult_cnt_nxt = MULT_LOAD;
                end
            end
            MULT_BUSY: begin
                if (Exception) begin
                    state_nxt    = EXC_VEC;
                    cause_nxt    = ExcCause;
                    mult_cnt_nxt = 4'd0;
                end else begin
                    // Leaving on a count of 1 makes the total stall MULT_CYCLES,
                    // the issuing RUN cycle included.
                    mult_cnt_nxt = mult_cnt - 4'd1;
                    if (mult_cnt == 4'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            EXC_VEC: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt    = RUN;
                mult_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EPCWrite    = 1'b0;
        PCSrcExc    = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (Exception) begin
                        EPCWrite   = 1'b1;
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (BranchTaken) begin
                        PCWrite    = 1'b1;
                        IFIDWrite  = 1'b1;
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (MultStart) begin
                        // The multiply itself advances into EX, so no bubble here.
                        IDEX_Bubble = 1'b0;
                    end else if (load_use) begin
                        IDEX_Bubble = 1'b1;
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDWrite = 1'b1;
                    end
                end
                MULT_BUSY: begin
                    if (Exception) begin
                        EPCWrite   = 1'b1;
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else begin
                        IDEX_Bubble = 1'b1;
                    end
                end
                EXC_VEC: begin
                    PCWrite    = 1'b1;
                    PCSrcExc   = 1'b1;
                    IFID_Flush = 1'b1;
                end
                default: begin
                    PCWrite   = 1'b1;
                    IFIDWrite = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int CNT_WIDTH   = 6;
    localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 IDEX_MemRead = 1'b0;
    logic [4:0]           IDEX_Rt = 5'd0;
    logic [4:0]           IFID_Rs = 5'd0;
    logic [4:0]           IFID_Rt = 5'd0;
    logic                 IFID_UsesRt = 1'b0;
    logic                 BranchTaken = 1'b0;
    logic                 MultStart = 1'b0;
    logic                 Exception = 1'b0;
    logic [1:0]           ExcCause = 2'd0;
    logic                 PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush;
    logic                 EPCWrite, PCSrcExc;
    logic [1:0]           CauseOut;
    logic [CNT_WIDTH-1:0] StallCycles;
    logic [6:0]           outs;

    hazard_stall_ctrl #(
        .PC_WIDTH(6), .MULT_CYCLES(MULT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .MultStart(MultStart),
        .Exception(Exception), .ExcCause(ExcCause),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .EPCWrite(EPCWrite), .PCSrcExc(PCSrcExc),
        .CauseOut(CauseOut), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, EPCWrite, PCSrcExc}
    assign outs = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, EPCWrite, PCSrcExc};

    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0010000;
    localparam logic [6:0] O_MULT  = 7'b0000000;
    localparam logic [6:0] O_BR    = 7'b1101100;
    localparam logic [6:0] O_EXC   = 7'b0001110;
    localparam logic [6:0] O_VEC   = 7'b1001001;

    typedef struct {
        logic       memread;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       ms;
        logic       exc;
        logic [1:0] cause;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
        logic [1:0] cause;
        int         cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining multiplier bubbles, pending vector cycle, cause, stalls.
    int         m_busy;
    bit         m_vec;
    logic [1:0] m_cause;
    int         m_stalls;

    function automatic in_t mkin(input logic memread, input int idex_rt, input int rs,
                                 input int rt, input logic uses_rt, input logic br,
                                 input logic ms, input logic exc, input int cause);
        in_t r;
        r.memread = memread;
        r.idex_rt = 5'(idex_rt);
        r.rs      = 5'(rs);
        r.rt      = 5'(rt);
        r.uses_rt = uses_rt;
        r.br      = br;
        r.ms      = ms;
        r.exc     = exc;
        r.cause   = 2'(cause);
        return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input logic [6:0] exp, input int cause, input int cnt);
        vec_t v;
        v.in    = i;
        v.exp   = exp;
        v.cause = 2'(cause);
        v.cnt   = cnt;
        return v;
    endfunction

    function automatic logic [6:0] model_out(input in_t i);
        bit lu;
        lu = i.memread && (i.idex_rt != 0) &&
             ((i.idex_rt == i.rs) || (i.uses_rt && (i.idex_rt == i.rt)));
        if (m_vec)      return O_VEC;
        if (m_busy > 0) return i.exc ? O_EXC : O_STALL;
        if (i.exc)      return O_EXC;
        if (i.br)       return O_BR;
        if (i.ms)       return O_MULT;
        if (lu)         return O_STALL;
        return O_RUN;
    endfunction

    task automatic model_step(input in_t i);
        logic [6:0] o;
        o = model_out(i);
        if (!o[6] && m_stalls < CNT_MAX) m_stalls++;
        if (m_vec) begin
            m_vec = 0;
        end else if (i.exc) begin
            m_vec   = 1;
            m_busy  = 0;
            m_cause = i.cause;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (!i.br && i.ms) begin
            m_busy = MULT_CYCLES - 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        IDEX_MemRead = i.memread;
        IDEX_Rt      = i.idex_rt;
        IFID_Rs      = i.rs;
        IFID_Rt      = i.rt;
        IFID_UsesRt  = i.uses_rt;
        BranchTaken  = i.br;
        MultStart    = i.ms;
        Exception    = i.exc;
        ExcCause     = i.cause;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("reset outputs", int'(outs), 0);
        chk("reset CauseOut", int'(CauseOut), 0);
        chk("reset StallCycles", int'(StallCycles), 0);
        @(negedge clk);
        rst      = 1'b1;
        m_busy   = 0;
        m_vec    = 0;
        m_cause  = 2'd0;
        m_stalls = 0;
    endtask

    task automatic vec_cycle(input vec_t v, input string nm);
        @(negedge clk);
        drive(v.in);
        #1;
        chk({nm, " outs"}, int'(outs), int'(v.exp));
        chk({nm, " CauseOut"}, int'(CauseOut), int'(v.cause));
        chk({nm, " StallCycles"}, int'(StallCycles), v.cnt);
        @(posedge clk);
    endtask

    task automatic rand_cycle(input int n);
        in_t i;
        i = mkin($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 3));
        @(negedge clk);
        drive(i);
        #1;
        chk($sformatf("rand%0d outs", n), int'(outs), int'(model_out(i)));
        chk($sformatf("rand%0d CauseOut", n), int'(CauseOut), int'(m_cause));
        chk($sformatf("rand%0d StallCycles", n), int'(StallCycles), m_stalls);
        @(posedge clk);
        model_step(i);
    endtask

    vec_t tbl[15];
    in_t  idle;

    initial begin
        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mkv(idle,                                O_RUN,   0, 0);
        tbl[1]  = mkv(mkin(1, 5, 5, 0, 0, 0, 0, 0, 0),     O_STALL, 0, 0);
        tbl[2]  = mkv(idle,                                O_RUN,   0, 1);
        tbl[3]  = mkv(mkin(1, 7, 3, 7, 1, 0, 0, 0, 0),     O_STALL, 0, 1);
        tbl[4]  = mkv(mkin(1, 7, 3, 7, 0, 0, 0, 0, 0),     O_RUN,   0, 2);
        tbl[5]  = mkv(mkin(1, 0, 0, 0, 1, 0, 0, 0, 0),     O_RUN,   0, 2);
        tbl[6]  = mkv(mkin(1, 5, 5, 0, 0, 1, 1, 0, 0),     O_BR,    0, 2);
        tbl[7]  = mkv(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0),     O_MULT,  0, 2);
        tbl[8]  = mkv(mkin(0, 0, 0, 0, 0, 1, 1, 0, 0),     O_STALL, 0, 3);
        tbl[9]  = mkv(idle,                                O_STALL, 0, 4);
        tbl[10] = mkv(idle,                                O_STALL, 0, 5);
        tbl[11] = mkv(idle,                                O_RUN,   0, 6);
        tbl[12] = mkv(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1),     O_EXC,   0, 6);
        tbl[13] = mkv(mkin(1, 5, 5, 0, 0, 0, 0, 1, 3),     O_VEC,   1, 7);
        tbl[14] = mkv(idle,                                O_RUN,   1, 7);

        do_reset();
        for (int k = 0; k < 15; k++) vec_cycle(tbl[k], $sformatf("tbl%0d", k));

        // Free run
        do_reset();
        for (int k = 0; k < 10; k++) vec_cycle(mkv(idle, O_RUN, 0, 0), $sformatf("free%0d", k));

        // Exception in the second multiplier-busy cycle; second exception masked
        do_reset();
        vec_cycle(mkv(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0), O_MULT, 0, 0), "exc mult start");
        vec_cycle(mkv(idle, O_STALL, 0, 1), "exc busy1");
        vec_cycle(mkv(mkin(0, 0, 0, 0, 0, 0, 0, 1, 2), O_EXC, 0, 2), "exc capture");
        vec_cycle(mkv(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1), O_VEC, 2, 3), "exc vector");
        vec_cycle(mkv(idle, O_RUN, 2, 3), "exc resume");

        // Asynchronous reset in the middle of a multiplier stall
        do_reset();
        vec_cycle(mkv(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0), O_MULT, 0, 0), "arst mult start");
        vec_cycle(mkv(idle, O_STALL, 0, 1), "arst busy1");
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst outs", int'(outs), 0);
        chk("arst StallCycles", int'(StallCycles), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst release outs", int'(outs), int'(O_RUN));
        @(posedge clk);
        vec_cycle(mkv(idle, O_RUN, 0, 0), "arst resume");

        // Stall counter saturation
        do_reset();
        for (int k = 0; k < CNT_MAX + 8; k++) begin
            @(negedge clk);
            drive(mkin(1, 9, 9, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
        end
        @(negedge clk);
        drive(idle);
        #1;
        chk("saturate StallCycles", int'(StallCycles), CNT_MAX);
        chk("saturate outs", int'(outs), int'(O_RUN));

        // Randomized traffic against the reference model
        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int k = $urandom_range(30, 150); k > 0; k--) rand_cycle(s * 1000 + k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
